// File: rtl/md_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Fixed-latency busy window per operation, D-stage stall request, mthi/mtlo writes.
module md_seq_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  input  logic        md_use_d,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int         DATA_W    = 32;
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                sgn_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [2*DATA_W-1:0] mul_res;
  logic [2*DATA_W-1:0] div_res;

  // Full 64-bit product; a 33-bit signed extension covers both signed and unsigned forms.
  function automatic logic [2*DATA_W-1:0] mul_full(input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] y,
                                                    input logic              sgn);
    logic signed [DATA_W:0]     xs;
    logic signed [DATA_W:0]     ys;
    logic signed [2*DATA_W+1:0] p;
    xs = {sgn & x[DATA_W-1], x};
    ys = {sgn & y[DATA_W-1], y};
    p  = xs * ys;
    return p[2*DATA_W-1:0];
  endfunction

  // Magnitude divide then sign fix-up; returns {remainder, quotient}.
  // The 0x80000000 / -1 case falls out as quotient 0x80000000, remainder 0.
  function automatic logic [2*DATA_W-1:0] div_full(input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] y,
                                                    input logic              sgn);
    logic              xn;
    logic              yn;
    logic [DATA_W-1:0] xm;
    logic [DATA_W-1:0] ym;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    xn = sgn & x[DATA_W-1];
    yn = sgn & y[DATA_W-1];
    xm = xn ? -x : x;
    ym = yn ? -y : y;
    q  = xm / ym;
    r  = xm % ym;
    if (xn ^ yn) q = -q;
    if (xn)      r = -r;
    return {r, q};
  endfunction

  assign mul_res = mul_full(a_q, b_q, sgn_q);
  assign div_res = div_full(a_q, b_q, sgn_q);
  assign stall   = md_use_d & (busy | start);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= ~op[0];
            busy  <= 1'b1;
            if (op[1]) begin
              state <= DIV;
              cnt   <= DIV_LOAD;
            end else begin
              state <= MUL;
              cnt   <= MULT_LOAD;
            end
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        MUL, DIV: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (state == MUL)     {hi, lo} <= mul_res;
            else if (b_q != '0)   {hi, lo} <= div_res;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/md_seq_ctrl.md
MD_SEQ_CTRL -- requirements
Module: md_seq_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  E-stage issues a mult/div operation this cycle.
REQ-006 op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu; sampled only with start.
REQ-007 a, b  input  32 each  operands: rs value and rt value.
REQ-008 wr_hi, wr_lo  input  1 each  mthi and mtlo write enables.
REQ-009 wdata  input  32  data for mthi and mtlo.
REQ-010 md_use_d  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 hi, lo  output  32 each  architectural HI and LO registers.
REQ-012 busy  output  1  operation in progress.
REQ-013 stall  output  1  stall request to the D stage.

Function
REQ-014 States are IDLE, MUL and DIV; the state and a 4-bit down-counter are internal.
REQ-015 In IDLE with start=1 at edge T:
- latch a, b and op;
- enter MUL (op[1]=0) or DIV (op[1]=1);
- load the counter with MULT_CYCLES-1 or DIV_CYCLES-1.
REQ-016 busy SHALL be 1 exactly in MUL/DIV, i.e. for N cycles after edge T, where N is MULT_CYCLES or DIV_CYCLES.
REQ-017 In MUL/DIV the counter decrements each edge; at the edge where it reads 0:
- commit the result to hi/lo;
- return to IDLE.
The new hi/lo values are visible in the same cycle that busy falls.
REQ-018 mult: {hi,lo} = signed 32x32 product, 64 bits. multu: {hi,lo} = unsigned product.
REQ-019 div: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-020 divu: lo = unsigned quotient; hi = unsigned remainder.
REQ-021 Signed overflow: div with 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-022 Divide by zero (b=0, div or divu) SHALL still run DIV_CYCLES busy cycles, then leave hi/lo unchanged.
REQ-023 Results SHALL come from the operands latched at start; changes on a/b during busy have no effect.
REQ-024 start while busy=1 is ignored: no restart, no re-latch.
REQ-025 In IDLE with start=0:
- wr_hi loads hi <= wdata and wr_lo loads lo <= wdata at the next edge;
- both asserted together write both registers.
REQ-026 wr_hi/wr_lo are ignored while busy=1, and also in a cycle where start=1 (start has priority).
REQ-027 stall = md_use_d & (busy | start). This output is combinational with no added latency.
REQ-028 hi/lo SHALL change only per REQ-017, REQ-025 or reset.

Reset
REQ-029 rst=1 at an edge SHALL set:
- hi=0, lo=0;
- busy=0, state IDLE, counter=0;
- latched operands to 0.
REQ-030 Reset during MUL/DIV aborts the operation: no hi/lo commit, and busy=0 from the cycle after the reset edge.
REQ-031 Reset has priority over start, wr_hi and wr_lo in the same cycle.
REQ-032 stall SHALL be 0 after reset unless start=1 and md_use_d=1.

Verification
REQ-033 mult, a=0xFFFFFFFE (-2), b=3, at edge T:
- busy=1 for 5 cycles;
- at edge T+5: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
REQ-034 multu, a=0xFFFFFFFF, b=2: after 5 cycles, hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 div, a=-7 (0xFFFFFFF9), b=2:
- busy=1 for 10 cycles;
- then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-036 divu, a=100, b=0, with prior hi=0x11, lo=0x22:
- busy=1 for 10 cycles;
- then hi=0x11 and lo=0x22 unchanged.
REQ-037 Stall and ignored writes during an operation:
- during mult busy: md_use_d=1 -> stall=1; wr_lo=1, wdata=0x55 -> ignored;
- after busy falls: wr_lo with wdata=0x55 gives lo=0x55 at the next edge.
REQ-038 Reset mid-operation: div started, rst=1 on busy cycle 4 -> busy=0, hi=0, lo=0 with no later commit; a new mult issued afterwards completes normally.
